tdm_demux: RTL and testbench

//   Receive end of the time-division-multiplexed serial link.
//   The transmit side steers one of SLOTS inputs onto a single wire per bit time.

---
 rtl/tdm_demux.sv | 105 ++++++++++
 tb/tb_tdm_demux.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - TDM serial link receiver: frame-sync lock, slot steering, parallel frame output
module tdm_demux #(
  parameter int SLOTS = 8,
  parameter int CNT_W = 3
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             sync_i,
  input  logic             din_i,
  output logic [SLOTS-1:0] dout_o,
  output logic             frame_valid_o,
  output logic             sync_err_o,
  output logic             locked_o
);

  typedef enum logic {HUNT, RECV} state_t;

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SLOTS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SLOTS-1:0] frame_q, frame_d;
  logic [SLOTS-1:0] dout_q, dout_d;
  logic             fv_q, fv_d;
  logic             err_q, err_d;
  logic             locked_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    dout_d  = dout_q;
    fv_d    = 1'b0;
    err_d   = 1'b0;
    if (enable_i) begin
      case (state_q)
        HUNT: begin
          if (sync_i) begin
            frame_d    = '0;
            frame_d[0] = din_i;
            cnt_d      = CNT_W'(1);
            state_d    = RECV;
          end
        end
        RECV: begin
          if (cnt_q == '0) begin
            if (sync_i) begin
              frame_d    = '0;
              frame_d[0] = din_i;
              cnt_d      = CNT_W'(1);
            end else begin
              err_d   = 1'b1;
              frame_d = '0;
              cnt_d   = '0;
              state_d = HUNT;
            end
          end else if (sync_i) begin
            // Early marker: drop the partial frame and restart on this bit.
            err_d      = 1'b1;
            frame_d    = '0;
            frame_d[0] = din_i;
            cnt_d      = CNT_W'(1);
          end else if (cnt_q == LAST_SLOT) begin
            dout_d            = frame_q;
            dout_d[SLOTS-1]   = din_i;
            fv_d              = 1'b1;
            frame_d           = '0;
            cnt_d             = '0;
          end else begin
            frame_d[cnt_q] = din_i;
            cnt_d          = cnt_q + 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= HUNT;
      cnt_q    <= '0;
      frame_q  <= '0;
      dout_q   <= '0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      frame_q  <= frame_d;
      dout_q   <= dout_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
      locked_q <= (state_d == RECV);
    end
  end

  assign dout_o        = dout_q;
  assign frame_valid_o = fv_q;
  assign sync_err_o    = err_q;
  assign locked_o      = locked_q;

endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - directed self-checking bench for tdm_demux (SLOTS=8)
module tb_tdm_demux;

  logic       clock = 1'b0;
  logic       reset, enable, sync, din;
  logic [7:0] dout;
  logic       frame_valid, sync_err, locked;

  int checks   = 0;
  int failures = 0;

  tdm_demux #(.SLOTS(8), .CNT_W(3)) dut (
    .clock_i       (clock),
    .reset_i       (reset),
    .enable_i      (enable),
    .sync_i        (sync),
    .din_i         (din),
    .dout_o        (dout),
    .frame_valid_o (frame_valid),
    .sync_err_o    (sync_err),
    .locked_o      (locked)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic s, input logic d);
    @(negedge clock);
    enable = en;
    sync   = s;
    din    = d;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset  = 1'b1;
    enable = 1'b1;
    sync   = 1'b1;
    din    = 1'b1;
    @(posedge clock);
    #1;
    @(negedge clock);
    reset  = 1'b0;
    enable = 1'b0;
  endtask

  // Sends one full frame starting with sync; optional idle cycle after each strobe.
  task automatic send_frame(input logic [7:0] v, input logic [7:0] prev, input bit toggle);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i == 0, v[i]);
      if (i < 7) begin
        chk("mid_fv", frame_valid, 0);
        chk("mid_err", sync_err, 0);
        chk("mid_dout", dout, prev);
      end else begin
        chk("end_fv", frame_valid, 1);
        chk("end_err", sync_err, 0);
        chk("end_dout", dout, v);
        chk("end_locked", locked, 1);
      end
      if (toggle) begin
        step(1'b0, 1'b1, ~v[i]);
        chk("idle_fv", frame_valid, 0);
        chk("idle_err", sync_err, 0);
        chk("idle_dout", dout, (i == 7) ? v : prev);
      end
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; sync = 1'b0; din = 1'b0;
    do_reset();
    chk("rst_dout", dout, 0);
    chk("rst_fv", frame_valid, 0);
    chk("rst_err", sync_err, 0);
    chk("rst_locked", locked, 0);

    // HUNT ignores bits without sync
    step(1'b1, 1'b0, 1'b1);
    chk("hunt_locked", locked, 0);
    chk("hunt_err", sync_err, 0);

    // 1 + 2: single frame then back-to-back frame
    send_frame(8'h4D, 8'h00, 1'b0);
    send_frame(8'hB2, 8'h4D, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("b2b_fv_clear", frame_valid, 0);
    chk("b2b_dout_hold", dout, 8'hB2);

    // 3: early marker at slot 4, new frame 8'hA5 begins on that bit
    for (int i = 0; i < 4; i++) step(1'b1, i == 0, 1'b1);
    chk("pre_early_err", sync_err, 0);
    step(1'b1, 1'b1, 1'b1);
    chk("early_err", sync_err, 1);
    chk("early_fv", frame_valid, 0);
    chk("early_dout", dout, 8'hB2);
    chk("early_locked", locked, 1);
    for (int i = 1; i < 8; i++) begin
      step(1'b1, 1'b0, logic'((8'hA5 >> i) & 1));
      if (i == 1) chk("early_err_pulse", sync_err, 0);
    end
    chk("early_new_fv", frame_valid, 1);
    chk("early_new_dout", dout, 8'hA5);

    // 4: missing marker after a completed frame
    step(1'b1, 1'b0, 1'b1);
    chk("miss_err", sync_err, 1);
    chk("miss_locked", locked, 0);
    chk("miss_dout", dout, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b1);
      chk("miss_ign_err", sync_err, 0);
      chk("miss_ign_locked", locked, 0);
    end
    send_frame(8'h3C, 8'hA5, 1'b0);

    // 5: enable toggling every cycle
    send_frame(8'h4D, 8'h3C, 1'b1);

    // 6: reset mid-frame at slot 5, then 8'hFF
    for (int i = 0; i < 5; i++) step(1'b1, i == 0, 1'b1);
    do_reset();
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_locked", locked, 0);
    chk("mid_rst_fv", frame_valid, 0);
    send_frame(8'hFF, 8'h00, 1'b0);

    // Early marker on the last slot: dout unchanged
    for (int i = 0; i < 7; i++) step(1'b1, i == 0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("last_early_err", sync_err, 1);
    chk("last_early_fv", frame_valid, 0);
    chk("last_early_dout", dout, 8'hFF);
    for (int i = 1; i < 8; i++) step(1'b1, 1'b0, 1'b0);
    chk("last_early_new_dout", dout, 8'h00);
    chk("last_early_new_fv", frame_valid, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
